// File: rtl/led_status_ctrl_pkg.sv
// Shared definitions for the status-LED engine: blink FSM encodings, timer widths
// and the clock-to-millisecond divider helper.
package led_status_ctrl_pkg;

  localparam int CNT_W = 10;
  localparam int GAP_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } blink_state_e;

  function automatic int ms_div(input int clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond timebase: counts 0..DIV-1 and raises tick for the single cycle
// spent at the terminal count.
module ms_tick_gen #(
  parameter int DIV = 12000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/led_status_ctrl.sv
// Status-LED engine: heartbeat, NUM_CH retriggerable activity stretchers and an
// error blink-code player. Define LED_PWM_EN to add brightness gating of the LEDs.
module led_status_ctrl
  import led_status_ctrl_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int NUM_CH     = 2,
  parameter int PULSE_MS   = 100,
  parameter int HB_HALF_MS = 500,
  parameter int BLINK_MS   = 200,
  parameter int GAP_MS     = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] evt,
  input  logic              err_valid,
  input  logic [3:0]        err_code,
`ifdef LED_PWM_EN
  input  logic [3:0]        brightness,
`endif
  output logic              led_hb,
  output logic [NUM_CH-1:0] led_act,
  output logic              led_err,
  output logic              err_busy,
  output logic              err_drop
);

  logic              tick;
  logic              hb_raw;
  logic [NUM_CH-1:0] act_raw;
  logic              err_raw;
  logic              busy_raw;
  logic              drop_raw;

  ms_tick_gen #(.DIV(ms_div(CLK_FREQ))) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // A strobe on the same cycle as a tick reloads without decrementing.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_act
    logic [CNT_W-1:0] cnt;
    logic             lit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lit <= 1'b0;
      end else if (evt[i]) begin
        cnt <= CNT_W'(PULSE_MS);
        lit <= 1'b1;
      end else if (tick && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) lit <= 1'b0;
      end
    end

    assign act_raw[i] = lit;
  end

  logic [CNT_W-1:0] hb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt <= '0;
      hb_raw <= 1'b0;
    end else if (tick) begin
      if (hb_cnt == CNT_W'(HB_HALF_MS - 1)) begin
        hb_cnt <= '0;
        hb_raw <= ~hb_raw;
      end else begin
        hb_cnt <= hb_cnt + 1'b1;
      end
    end
  end

  // Blink-code player. Handshake: err_valid is a 1-cycle strobe with no ready;
  // err_code is sampled on that cycle, code 0 is discarded, and a code arriving
  // while busy parks in a one-deep pending slot (overwrite pulses err_drop).
  blink_state_e     state, state_n;
  logic [GAP_W-1:0] tmr, tmr_n;
  logic [3:0]       rem, rem_n;
  logic [3:0]       pend_code, pend_code_n;
  logic             pend_v, pend_v_n;
  logic             drop_n;
  logic             code_ok;
  logic             expire;

  assign code_ok = err_valid && (err_code != 4'd0);
  assign expire  = tick && (tmr <= GAP_W'(1));

  always_comb begin
    state_n     = state;
    tmr_n       = tmr;
    rem_n       = rem;
    pend_code_n = pend_code;
    pend_v_n    = pend_v;
    drop_n      = 1'b0;

    if ((state != ST_IDLE) && tick && (tmr != '0)) tmr_n = tmr - 1'b1;

    case (state)
      ST_IDLE: begin
        if (code_ok) begin
          state_n = ST_ON;
          rem_n   = err_code;
          tmr_n   = GAP_W'(BLINK_MS);
        end
      end
      ST_ON: begin
        if (expire) begin
          state_n = ST_OFF;
          tmr_n   = GAP_W'(BLINK_MS);
        end
      end
      ST_OFF: begin
        if (expire) begin
          rem_n = rem - 1'b1;
          if (rem == 4'd1) begin
            state_n = ST_GAP;
            tmr_n   = GAP_W'(GAP_MS);
          end else begin
            state_n = ST_ON;
            tmr_n   = GAP_W'(BLINK_MS);
          end
        end
      end
      ST_GAP: begin
        if (expire) begin
          if (pend_v) begin
            state_n  = ST_ON;
            rem_n    = pend_code;
            pend_v_n = 1'b0;
            tmr_n    = GAP_W'(BLINK_MS);
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A code consumed from pending this cycle frees the slot, so no drop.
    if (code_ok && (state != ST_IDLE)) begin
      drop_n      = pend_v_n;
      pend_code_n = err_code;
      pend_v_n    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      rem       <= '0;
      pend_code <= '0;
      pend_v    <= 1'b0;
      err_raw   <= 1'b0;
      busy_raw  <= 1'b0;
      drop_raw  <= 1'b0;
    end else begin
      state     <= state_n;
      tmr       <= tmr_n;
      rem       <= rem_n;
      pend_code <= pend_code_n;
      pend_v    <= pend_v_n;
      err_raw   <= (state_n == ST_ON);
      busy_raw  <= (state_n != ST_IDLE);
      drop_raw  <= drop_n;
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm;
  logic       gate;

  assign gate = (pwm < brightness);

  // Status flags go through the same output stage so every output shares the latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm      <= '0;
      led_hb   <= 1'b0;
      led_act  <= '0;
      led_err  <= 1'b0;
      err_busy <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      pwm      <= pwm + 1'b1;
      led_hb   <= hb_raw & gate;
      led_act  <= act_raw & {NUM_CH{gate}};
      led_err  <= err_raw & gate;
      err_busy <= busy_raw;
      err_drop <= drop_raw;
    end
  end
`else
  assign led_hb   = hb_raw;
  assign led_act  = act_raw;
  assign led_err  = err_raw;
  assign err_busy = busy_raw;
  assign err_drop = drop_raw;
`endif

endmodule
